// File: rtl/alu_pkg.sv
// Shared types for the tinyarch multi-cycle ALU: opcode encoding and controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SHR  = 4'd1,
        OP_SHL  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_MOV  = 4'd5,
        OP_LDI  = 4'd6,
        OP_MUL  = 4'd7,
        OP_NOT  = 4'd8,
        OP_LNOT = 4'd9,
        OP_SHO  = 4'd10,
        OP_ADC  = 4'd11,
        OP_EXIT = 4'd12,
        OP_NOP  = 4'd13,
        OP_JMP  = 4'd14,
        OP_MFHI = 4'd15
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// Radix-2 shift-add multiplier: the first iteration happens at start, so done pulses
// WIDTH-1 cycles later and the product is final while done is high.
module alu_mc_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] count;
    logic             busy;

    // Upper half accumulates the partial sum while the multiplier drains out of the lower half.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {sum, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                product <= step({{WIDTH{1'b0}}, b}, a);
                mcand   <= a;
                count   <= CNT_W'(WIDTH - 1);
                busy    <= 1'b1;
            end else if (busy) begin
                product <= step(product, mcand);
                count   <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked tinyarch ALU with registered outputs, multi-word shift chain (spill buffer)
// and a multi-cycle multiplier whose high half is read back with MFHI.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_e          operation,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             exit
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] W_AMT = CNT_W'(WIDTH);

    alu_state_e state, state_next;
    logic accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] spill, hi;
    logic             last_dir;
    logic [CNT_W-1:0] last_amt;

    logic [WIDTH-1:0]   result_next, spill_next, shift_res, shift_out;
    logic               carry_next, exit_next, dir_next, sh_dir;
    logic [CNT_W-1:0]   amt_next, req_amt, sh_amt;
    logic [2*WIDTH-1:0] sh_right, sh_left;
    logic [WIDTH:0]     sum;

    assign in_ready = (state == IDLE) && !exit;
    assign accept   = in_valid && in_ready;

    alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        case (state)
            IDLE: if (accept && operation == OP_MUL) begin
                mul_start  = 1'b1;
                state_next = MUL;
            end
            MUL: if (mul_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shifts run on a double-width word so the shifted-out bits land in the other half;
    // last_dir is 1 for right shifts.
    always_comb begin
        req_amt   = (op2 >= WIDTH'(WIDTH)) ? W_AMT : CNT_W'(op2);
        sh_dir    = (operation == OP_SHO) ? last_dir : (operation == OP_SHR);
        sh_amt    = (operation == OP_SHO) ? last_amt : req_amt;
        sh_right  = {op1, {WIDTH{1'b0}}} >> sh_amt;
        sh_left   = {{WIDTH{1'b0}}, op1} << sh_amt;
        shift_res = sh_dir ? sh_right[2*WIDTH-1:WIDTH] : sh_left[WIDTH-1:0];
        shift_out = sh_dir ? sh_right[WIDTH-1:0] : sh_left[2*WIDTH-1:WIDTH];
        sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, (operation == OP_ADC) && carry};

        result_next = '0;
        carry_next  = carry;
        exit_next   = exit;
        spill_next  = spill;
        dir_next    = last_dir;
        amt_next    = last_amt;
        case (operation)
            OP_ADD, OP_ADC: begin
                result_next = sum[WIDTH-1:0];
                carry_next  = sum[WIDTH];
            end
            OP_SHR, OP_SHL: begin
                result_next = shift_res;
                spill_next  = shift_out;
                dir_next    = sh_dir;
                amt_next    = req_amt;
            end
            OP_SHO: begin
                result_next = shift_res | spill;
                spill_next  = shift_out;
            end
            OP_OR:          result_next = op1 | op2;
            OP_AND:         result_next = op1 & op2;
            OP_MOV, OP_LDI: result_next = op2;
            OP_NOT:         result_next = ~op1;
            OP_LNOT:        result_next = {{(WIDTH-1){1'b0}}, op1 == '0};
            OP_MFHI:        result_next = hi;
            OP_EXIT:        exit_next   = 1'b1;
            default:        result_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            exit      <= 1'b0;
            spill     <= '0;
            hi        <= '0;
            last_dir  <= 1'b0;
            last_amt  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == MUL) begin
                if (mul_done) begin
                    result    <= mul_product[WIDTH-1:0];
                    hi        <= mul_product[2*WIDTH-1:WIDTH];
                    out_valid <= 1'b1;
                end
            end else if (accept && operation != OP_MUL) begin
                result    <= result_next;
                carry     <= carry_next;
                exit      <= exit_next;
                spill     <= spill_next;
                last_dir  <= dir_next;
                last_amt  <= amt_next;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, multi-cycle corner sequences,
// and randomized ops against an arithmetic reference model (WIDTH=8), plus a WIDTH=16 instance.
module tb_alu_mc;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    alu_op_e    operation = OP_NOP;
    logic [7:0] op1 = '0, op2 = '0;
    logic       in_ready, out_valid, carry, exit_flag;
    logic [7:0] result;

    logic        in_valid16 = 1'b0;
    alu_op_e     operation16 = OP_NOP;
    logic [15:0] op1_16 = '0, op2_16 = '0;
    logic        in_ready16, out_valid16, carry16, exit16;
    logic [15:0] result16;

    int checks = 0;
    int errors = 0;
    int m_carry, m_spill, m_hi, m_dir, m_amt;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cy;
    } vec_t;
    vec_t vecs[23];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .op1(op1), .op2(op2), .out_valid(out_valid),
        .result(result), .carry(carry), .exit(exit_flag)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .operation(operation16), .op1(op1_16), .op2(op2_16), .out_valid(out_valid16),
        .result(result16), .carry(carry16), .exit(exit16)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        operation = alu_op_e'(op);
        op1 = a;
        op2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        operation16 = alu_op_e'(op);
        op1_16 = a;
        op2_16 = b;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
    endtask

    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget && !out_valid) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        in_valid16 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference behaviour from the opcode rules using plain integer arithmetic.
    task automatic modelStep(input int op, input int a, input int b, output int r);
        int amt, full;
        amt = (b > 8) ? 8 : b;
        r = 0;
        case (op)
            0:  begin full = a + b;           r = full & 255; m_carry = full >> 8; end
            11: begin full = a + b + m_carry; r = full & 255; m_carry = full >> 8; end
            1:  begin r = a >> amt; m_spill = (a << (8 - amt)) & 255; m_dir = 1; m_amt = amt; end
            2:  begin r = (a << amt) & 255; m_spill = a >> (8 - amt); m_dir = 0; m_amt = amt; end
            10: begin
                if (m_dir == 1) begin
                    r = (a >> m_amt) | m_spill;
                    m_spill = (a << (8 - m_amt)) & 255;
                end else begin
                    r = ((a << m_amt) & 255) | m_spill;
                    m_spill = a >> (8 - m_amt);
                end
            end
            3:  r = a | b;
            4:  r = a & b;
            5, 6: r = b;
            7:  begin full = a * b; r = full & 255; m_hi = full >> 8; end
            8:  r = (~a) & 255;
            9:  r = (a == 0) ? 1 : 0;
            15: r = m_hi;
            default: r = 0;
        endcase
    endtask

    initial begin
        int cyc, seen, exp_r, op, a, b;

        vecs[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 1'b1};
        vecs[1]  = '{4'd11, 8'h01, 8'h01, 8'h03, 1'b0};
        vecs[2]  = '{4'd1,  8'hB5, 8'h03, 8'h16, 1'b0};
        vecs[3]  = '{4'd10, 8'h0F, 8'h00, 8'hA1, 1'b0};
        vecs[4]  = '{4'd2,  8'hB5, 8'h03, 8'hA8, 1'b0};
        vecs[5]  = '{4'd10, 8'h0F, 8'h00, 8'h7D, 1'b0};
        vecs[6]  = '{4'd2,  8'h81, 8'h09, 8'h00, 1'b0};
        vecs[7]  = '{4'd10, 8'h00, 8'h00, 8'h81, 1'b0};
        vecs[8]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[9]  = '{4'd3,  8'h0C, 8'h30, 8'h3C, 1'b1};
        vecs[10] = '{4'd4,  8'h0C, 8'h3C, 8'h0C, 1'b1};
        vecs[11] = '{4'd8,  8'h5A, 8'h00, 8'hA5, 1'b1};
        vecs[12] = '{4'd9,  8'h00, 8'h00, 8'h01, 1'b1};
        vecs[13] = '{4'd9,  8'h05, 8'h00, 8'h00, 1'b1};
        vecs[14] = '{4'd5,  8'h11, 8'h77, 8'h77, 1'b1};
        vecs[15] = '{4'd6,  8'h11, 8'h88, 8'h88, 1'b1};
        vecs[16] = '{4'd11, 8'h10, 8'h20, 8'h31, 1'b0};
        vecs[17] = '{4'd13, 8'h12, 8'h34, 8'h00, 1'b0};
        vecs[18] = '{4'd14, 8'h12, 8'h34, 8'h00, 1'b0};
        vecs[19] = '{4'd1,  8'h80, 8'h08, 8'h00, 1'b0};
        vecs[20] = '{4'd10, 8'hFF, 8'h00, 8'h80, 1'b0};
        vecs[21] = '{4'd2,  8'h3C, 8'h00, 8'h3C, 1'b0};
        vecs[22] = '{4'd10, 8'h01, 8'h00, 8'h01, 1'b0};

        doReset();
        checkOutput("reset_result", 32'(result), 32'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_carry", 32'(carry), 32'h0);
        checkOutput("reset_exit", 32'(exit_flag), 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
            checkOutput($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
            checkOutput($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].cy));
            checkOutput($sformatf("vec%0d_ready", i), 32'(in_ready), 32'h1);
        end
        @(posedge clk); #1;
        checkOutput("valid_pulse_ends", 32'(out_valid), 32'h0);

        // MUL with an ADD request held during the busy window; it must be ignored.
        applyStimulus(4'd7, 8'hFF, 8'hFF);
        checkOutput("mul_busy_ready", 32'(in_ready), 32'h0);
        checkOutput("mul_no_early_valid", 32'(out_valid), 32'h0);
        operation = OP_ADD; op1 = 8'hFF; op2 = 8'hFF; in_valid = 1'b1;
        waitValid(20, cyc);
        in_valid = 1'b0;
        checkOutput("mul_latency", 32'(cyc), 32'd8);
        checkOutput("mul_valid", 32'(out_valid), 32'h1);
        checkOutput("mul_result", 32'(result), 32'h01);
        checkOutput("mul_ready_back", 32'(in_ready), 32'h1);
        checkOutput("mul_carry_kept", 32'(carry), 32'h0);
        applyStimulus(4'd15, 8'h00, 8'h00);
        checkOutput("mfhi_result", 32'(result), 32'hFE);

        // Reset during the fourth MUL cycle aborts it.
        applyStimulus(4'd7, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_result", 32'(result), 32'h0);
        checkOutput("abort_ready", 32'(in_ready), 32'h1);
        checkOutput("abort_carry", 32'(carry), 32'h0);
        checkOutput("abort_exit", 32'(exit_flag), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("abort_no_valid", 32'(seen), 32'h0);
        applyStimulus(4'd15, 8'h00, 8'h00);
        checkOutput("abort_hi_cleared", 32'(result), 32'h00);
        applyStimulus(4'd10, 8'h5A, 8'h00);
        checkOutput("sho_no_prior_shift", 32'(result), 32'h5A);

        // EXIT: one pulse, sticky flag, later requests ignored until reset.
        applyStimulus(4'd0, 8'hF0, 8'h20);
        checkOutput("pre_exit_carry", 32'(carry), 32'h1);
        applyStimulus(4'd12, 8'h33, 8'h44);
        checkOutput("exit_valid", 32'(out_valid), 32'h1);
        checkOutput("exit_flag", 32'(exit_flag), 32'h1);
        checkOutput("exit_result", 32'(result), 32'h0);
        checkOutput("exit_ready", 32'(in_ready), 32'h0);
        applyStimulus(4'd0, 8'h01, 8'h01);
        checkOutput("post_exit_no_valid", 32'(out_valid), 32'h0);
        checkOutput("post_exit_result", 32'(result), 32'h0);
        checkOutput("post_exit_carry", 32'(carry), 32'h1);
        doReset();
        checkOutput("exit_cleared", 32'(exit_flag), 32'h0);
        checkOutput("exit_ready_back", 32'(in_ready), 32'h1);

        m_carry = 0; m_spill = 0; m_hi = 0; m_dir = 0; m_amt = 0;
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 12) op = 13;
            a = int'($urandom_range(0, 255));
            b = (op == 1 || op == 2) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
            modelStep(op, a, b, exp_r);
            applyStimulus(op[3:0], a[7:0], b[7:0]);
            if (op == 7) begin
                waitValid(20, cyc);
                checkOutput($sformatf("rnd%0d_mul_latency", i), 32'(cyc), 32'd8);
            end
            checkOutput($sformatf("rnd%0d_op%0d_valid", i, op), 32'(out_valid), 32'h1);
            checkOutput($sformatf("rnd%0d_op%0d_result", i, op), 32'(result), 32'(exp_r));
            checkOutput($sformatf("rnd%0d_op%0d_carry", i, op), 32'(carry), 32'(m_carry));
        end

        applyStimulus16(4'd0, 16'hFFFF, 16'h0001);
        checkOutput("w16_add_result", 32'(result16), 32'h0000);
        checkOutput("w16_add_carry", 32'(carry16), 32'h1);
        applyStimulus16(4'd7, 16'h0100, 16'h0100);
        cyc = 0;
        while (cyc < 40 && !out_valid16) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("w16_mul_latency", 32'(cyc), 32'd16);
        checkOutput("w16_mul_result", 32'(result16), 32'h0000);
        applyStimulus16(4'd15, 16'h0000, 16'h0000);
        checkOutput("w16_mfhi", 32'(result16), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
